// File: rtl/tick_gen_if.sv
// tick_gen_if -- control/status bundle for tick_gen.
//
// Signals:
//   en       run enable; 0 forces the generator idle
//   ld       load strobe for low_in/high_in
//   low_in   requested LOW-phase length (cycles)
//   high_in  requested HIGH-phase length (cycles)
//   single   one-shot request, sampled while idle (TICK_GEN_ONESHOT_EN only)
//   y        registered waveform
//   rise     one-cycle pulse on the first cycle of a HIGH phase
//   cnt      cycles elapsed in the current phase
//   pend     a load is queued and not yet applied
//
// Modports: master drives the controls, slave is the generator.
// WIDTH must match the WIDTH of the tick_gen attached to it.
interface tick_gen_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] low_in;
  logic [WIDTH-1:0] high_in;
`ifdef TICK_GEN_ONESHOT_EN
  logic             single;
`endif
  logic             y;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic             pend;

  modport master (
`ifdef TICK_GEN_ONESHOT_EN
    output single,
`endif
    output en, ld, low_in, high_in,
    input  y, rise, cnt, pend
  );

  modport slave (
`ifdef TICK_GEN_ONESHOT_EN
    input  single,
`endif
    input  en, ld, low_in, high_in,
    output y, rise, cnt, pend
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen -- programmable LOW/HIGH waveform generator.
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    tick_gen_if.slave (en, ld, low_in, high_in, [single] in;
//          y, rise, cnt, pend out)
//
// Parameters: WIDTH (phase length / counter width), INIT_LOW and INIT_HIGH
// (phase lengths loaded at reset).
//
// Optional feature: define TICK_GEN_ONESHOT_EN to add bus.single and a DONE
// state; with single=1 sampled while idle, the generator emits one period and
// then parks in DONE (y=0, cnt=0) until en drops.
//
// A period is one LOW phase followed by one HIGH phase. New lengths written via
// ld are held pending and only take effect at a period end or while idle, so a
// running period is never distorted.
module tick_gen #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned INIT_LOW  = 4,
  parameter int unsigned INIT_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  tick_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
`ifdef TICK_GEN_ONESHOT_EN
    ,
    DONE = 2'd3
`endif
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           nxt_state;
  state_t           start_state;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] nxt_cnt;
  logic [WIDTH-1:0] low_len;
  logic [WIDTH-1:0] high_len;
  logic [WIDTH-1:0] low_pend;
  logic [WIDTH-1:0] high_pend;
  logic [WIDTH-1:0] eff_low;
  logic [WIDTH-1:0] eff_high;
  logic             y_q;
  logic             rise_q;
  logic             pend_q;
  logic             low_last;
  logic             high_last;
  logic             period_end;
  logic             apply;
`ifdef TICK_GEN_ONESHOT_EN
  logic             shot_q;
`endif

  always_comb begin
    low_last  = (cnt_q == low_len - ONE);
    high_last = (cnt_q == high_len - ONE);

    // With high_len=0 the period has no HIGH phase, so the last LOW cycle is
    // the period boundary; otherwise a queued load could never be applied.
    period_end = bus.en &&
                 ((state == HIGH && high_last) ||
                  (state == LOW && low_last && high_len == '0));

    apply    = pend_q && (state == IDLE || period_end);
    eff_low  = apply ? low_pend  : low_len;
    eff_high = apply ? high_pend : high_len;

    // First state of a new period, using the lengths that period will run with.
    if (eff_low != '0) begin
      start_state = LOW;
    end else if (eff_high != '0) begin
      start_state = HIGH;
    end else begin
      start_state = IDLE;
    end

    nxt_state = state;
    nxt_cnt   = cnt_q + ONE;

    if (!bus.en) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = start_state;
          nxt_cnt   = '0;
        end
        LOW: begin
          if (low_last) begin
            nxt_state = (high_len != '0) ? HIGH : start_state;
            nxt_cnt   = '0;
          end
        end
        HIGH: begin
          if (high_last) begin
            nxt_state = start_state;
            nxt_cnt   = '0;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      endcase
`ifdef TICK_GEN_ONESHOT_EN
      if (state == DONE) begin
        nxt_state = DONE;
        nxt_cnt   = '0;
      end else if (period_end && shot_q) begin
        nxt_state = DONE;
        nxt_cnt   = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_q     <= '0;
      y_q       <= 1'b0;
      rise_q    <= 1'b0;
      pend_q    <= 1'b0;
      low_len   <= WIDTH'(INIT_LOW);
      high_len  <= WIDTH'(INIT_HIGH);
      low_pend  <= '0;
      high_pend <= '0;
`ifdef TICK_GEN_ONESHOT_EN
      shot_q    <= 1'b0;
`endif
    end else begin
      state  <= nxt_state;
      cnt_q  <= nxt_cnt;
      y_q    <= (nxt_state == HIGH);
      // HIGH->HIGH (low_len=0) is a continuous high level, not a new edge.
      rise_q <= (nxt_state == HIGH) && (state != HIGH);

      if (apply) begin
        low_len  <= low_pend;
        high_len <= high_pend;
      end

      // A load coinciding with an apply queues behind it rather than
      // being consumed at the same boundary.
      if (bus.ld) begin
        low_pend  <= bus.low_in;
        high_pend <= bus.high_in;
        pend_q    <= 1'b1;
      end else if (apply) begin
        pend_q    <= 1'b0;
      end

`ifdef TICK_GEN_ONESHOT_EN
      if (state == IDLE) begin
        shot_q <= bus.single;
      end
`endif
    end
  end

  assign bus.y    = y_q;
  assign bus.rise = rise_q;
  assign bus.cnt  = cnt_q;
  assign bus.pend = pend_q;

endmodule
